gray_rx_decoder: RTL and testbench

Registered receiver for Gray-coded counter values: samples a Gray word from a Gray counter or a clock-domain-crossed Gray pointer, decodes it to binary with an XOR prefix chain, and checks that every successive value is a legal single-step move. Sits at the consuming end of the Gray count path in the counters library. Feeds binary count, direction pulses and error status to downstream logic.

---
 rtl/gray_rx_decoder.sv | 115 +++++++++++
 tb/tb_gray_rx_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_rx_decoder.sv
// Gray-coded count receiver: captures a qualified Gray word, decodes it to binary
// and classifies each move against the previous value as up, down, hold or error.
module gray_rx_decoder #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 gray_valid,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 step_up,
    output logic                 step_down,
    output logic                 step_err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic [WIDTH-1:0]     g_q, g_d;
    logic                 v1_q, v1_d;
    logic                 primed_q, primed_d;
    logic [WIDTH-1:0]     bin_out_q, bin_out_d;
    logic                 bin_valid_q, bin_valid_d;
    logic                 step_up_q, step_up_d;
    logic                 step_down_q, step_down_d;
    logic                 step_err_q, step_err_d;
    logic                 err_sticky_q, err_sticky_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     diff;

    always_comb begin
        g_d  = gray_valid ? gray_in : g_q;
        v1_d = gray_valid;

        // Each binary bit is the parity of the Gray bits at and above it.
        b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b[i] = ^(g_q >> i);
        end
        diff = b - bin_out_q;

        primed_d    = primed_q;
        bin_out_d   = bin_out_q;
        bin_valid_d = 1'b0;
        step_up_d   = 1'b0;
        step_down_d = 1'b0;
        step_err_d  = 1'b0;
        if (v1_q) begin
            bin_out_d   = b;
            bin_valid_d = 1'b1;
            if (!primed_q) begin
                primed_d = 1'b1;
            end else if (diff == WIDTH'(1)) begin
                step_up_d = 1'b1;
            end else if (diff == {WIDTH{1'b1}}) begin
                step_down_d = 1'b1;
            end else if (diff != '0) begin
                step_err_d = 1'b1;
            end
        end

        // A new error outranks a simultaneous clear, leaving exactly one counted.
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        if (step_err_d) begin
            err_sticky_d = 1'b1;
            if (clr_err) begin
                err_count_d = ERR_CNT_W'(1);
            end else if (err_count_q != {ERR_CNT_W{1'b1}}) begin
                err_count_d = err_count_q + ERR_CNT_W'(1);
            end
        end else if (clr_err) begin
            err_sticky_d = 1'b0;
            err_count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q          <= '0;
            v1_q         <= 1'b0;
            primed_q     <= 1'b0;
            bin_out_q    <= '0;
            bin_valid_q  <= 1'b0;
            step_up_q    <= 1'b0;
            step_down_q  <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            g_q          <= g_d;
            v1_q         <= v1_d;
            primed_q     <= primed_d;
            bin_out_q    <= bin_out_d;
            bin_valid_q  <= bin_valid_d;
            step_up_q    <= step_up_d;
            step_down_q  <= step_down_d;
            step_err_q   <= step_err_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bin_out    = bin_out_q;
    assign bin_valid  = bin_valid_q;
    assign step_up    = step_up_q;
    assign step_down  = step_down_q;
    assign step_err   = step_err_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Scoreboard bench for gray_rx_decoder: directed Gray samples with hand-decoded
// binary values; a monitor pops expectations whenever bin_valid pulses.
module tb_gray_rx_decoder;

    localparam int WIDTH     = 8;
    localparam int ERR_CNT_W = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [WIDTH-1:0]     gray_in = '0;
    logic                 gray_valid = 1'b0;
    logic                 clr_err = 1'b0;
    logic [WIDTH-1:0]     bin_out;
    logic                 bin_valid;
    logic                 step_up;
    logic                 step_down;
    logic                 step_err;
    logic                 err_sticky;
    logic [ERR_CNT_W-1:0] err_count;

    gray_rx_decoder #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .gray_valid(gray_valid),
        .clr_err(clr_err), .bin_out(bin_out), .bin_valid(bin_valid),
        .step_up(step_up), .step_down(step_down), .step_err(step_err),
        .err_sticky(err_sticky), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int                   cyc;
        logic [WIDTH-1:0]     bin;
        logic                 up;
        logic                 down;
        logic                 err;
        logic                 sticky;
        logic [ERR_CNT_W-1:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference state
    logic                 m_primed = 1'b0;
    logic [WIDTH-1:0]     m_last = '0;
    logic                 m_sticky = 1'b0;
    logic [ERR_CNT_W-1:0] m_count = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one valid sample; clr raises clr_err on the cycle the sample is judged.
    task automatic send(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] b, input logic clr);
        exp_t e;
        logic [WIDTH-1:0] d;
        e = '0;
        e.cyc = cyc + 2;
        e.bin = b;
        d = b - m_last;
        if (m_primed) begin
            if (d == 8'h01) e.up = 1'b1;
            else if (d == 8'hFF) e.down = 1'b1;
            else if (d != 8'h00) e.err = 1'b1;
        end
        m_primed = 1'b1;
        m_last = b;
        if (e.err) begin
            m_sticky = 1'b1;
            if (clr) m_count = 2'd1;
            else if (m_count != 2'd3) m_count = m_count + 2'd1;
        end else if (clr) begin
            m_sticky = 1'b0;
            m_count = 2'd0;
        end
        e.sticky = m_sticky;
        e.count = m_count;
        exp_q.push_back(e);
        gray_in = g;
        gray_valid = 1'b1;
        clr_err = 1'b0;
        @(negedge clk);
        gray_valid = 1'b0;
        clr_err = clr;
        if (clr) begin
            @(negedge clk);
            clr_err = 1'b0;
        end
    endtask

    task automatic clear();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_sticky = 1'b0;
        m_count = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bin_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_valid: got bin_out 0x%0h with no expected sample", bin_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency_cycle", cyc, e.cyc);
                    chk("bin_out", bin_out, e.bin);
                    chk("step_up", step_up, e.up);
                    chk("step_down", step_down, e.down);
                    chk("step_err", step_err, e.err);
                    chk("err_sticky", err_sticky, e.sticky);
                    chk("err_count", err_count, e.count);
                end
            end else begin
                chk("idle_pulses", {step_up, step_down, step_err, bin_valid}, 4'b0000);
            end
        end
    end

    initial begin : stim
        int t;
        idle(3);
        chk("rst_bin_out", bin_out, 0);
        chk("rst_flags", {bin_valid, step_up, step_down, step_err, err_sticky}, 0);
        chk("rst_err_count", err_count, 0);
        rst_n = 1'b1;
        idle(1);

        // up count, back-to-back
        send(8'h00, 8'h00, 1'b0);
        send(8'h01, 8'h01, 1'b0);
        send(8'h03, 8'h02, 1'b0);
        send(8'h02, 8'h03, 1'b0);
        send(8'h06, 8'h04, 1'b0);
        idle(3);

        // wrap and down: 4 -> 255 is illegal, then 255 -> 0 -> 255
        send(8'h80, 8'hFF, 1'b0);
        idle(3);
        clear();
        send(8'h00, 8'h00, 1'b0);
        send(8'h80, 8'hFF, 1'b0);
        idle(3);
        clear();

        // hold and illegal jump
        send(8'h01, 8'h01, 1'b0);
        send(8'h01, 8'h01, 1'b0);
        send(8'h07, 8'h05, 1'b0);
        idle(3);
        clear();

        // saturation at 3
        send(8'h30, 8'h20, 1'b0);
        send(8'h60, 8'h40, 1'b0);
        send(8'h50, 8'h60, 1'b0);
        send(8'hC0, 8'h80, 1'b0);
        send(8'hF0, 8'hA0, 1'b0);
        idle(3);
        clear();

        // clear colliding with an error, then a lone clear
        send(8'h00, 8'h00, 1'b0);
        send(8'h77, 8'h5A, 1'b0);
        idle(2);
        send(8'h30, 8'h20, 1'b1);
        idle(3);
        clear();
        chk("clr_alone_sticky", err_sticky, 0);
        chk("clr_alone_count", err_count, 0);

        // build count=3, bin=0x5A, then reset with a sample in flight
        send(8'h00, 8'h00, 1'b0);
        send(8'h30, 8'h20, 1'b0);
        send(8'h77, 8'h5A, 1'b0);
        idle(3);
        chk("pre_rst_count", err_count, 3);
        chk("pre_rst_bin", bin_out, 8'h5A);
        gray_in = 8'h01;
        gray_valid = 1'b1;
        @(posedge clk);
        #2;
        gray_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_bin_out", bin_out, 0);
        chk("async_rst_flags", {bin_valid, step_up, step_down, step_err, err_sticky}, 0);
        chk("async_rst_count", err_count, 0);
        m_primed = 1'b0;
        m_sticky = 1'b0;
        m_count = '0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send(8'h0F, 8'h0A, 1'b0);

        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        idle(2);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
